// File: rtl/rf_wb_arbiter.sv
// Purpose: round-robin arbiter sharing the RF write port between ALU and MEM writeback; optional post-reset zero-fill scrub (RF_WB_SCRUB_EN).
// Latency: one cycle from handshake to registered RF write; scrub takes NREGS edges after reset release.
// Backpressure: at most one ready per cycle, loser is granted next cycle; both readies held low during scrub and reset.
module rf_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            alu_valid_i,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [XLEN-1:0] alu_wd_i,
    output logic            alu_ready_o,
    input  logic            mem_valid_i,
    input  logic [AW-1:0]   mem_rd_i,
    input  logic [XLEN-1:0] mem_wd_i,
    output logic            mem_ready_o,
    output logic            rf_regwrite_o,
    output logic [AW-1:0]   rf_rd_o,
    output logic [XLEN-1:0] rf_wd_o,
    output logic            init_done_o
);

    // Register index must be able to address every architectural register.
    if (NREGS > (1 << AW)) begin : g_bad_aw
        $error("rf_wb_arbiter: AW too small for NREGS");
    end

    localparam logic PRIO_ALU = 1'b0;
    localparam logic PRIO_MEM = 1'b1;

    logic prio_q;
    logic arb_active;
    logic alu_xfer;
    logic mem_xfer;

`ifdef RF_WB_SCRUB_EN
    typedef enum logic {ST_INIT, ST_ARB} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] cnt_q;
    logic          scrub_wr;

    // State register: INIT after reset, ARB once the scrub is finished.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ST_INIT;
        else         state_q <= state_d;
    end

    // Next state: leave INIT on the edge that writes the last register.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && cnt_q == AW'(NREGS - 1)) state_d = ST_ARB;
    end

    // Scrub index counts only while scrubbing.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                cnt_q <= '0;
        else if (state_q == ST_INIT) cnt_q <= cnt_q + 1'b1;
    end

    // State-derived outputs; init_done is the ARB state itself, so it rises on edge NREGS.
    always_comb begin
        scrub_wr    = (state_q == ST_INIT);
        arb_active  = (state_q == ST_ARB);
        init_done_o = (state_q == ST_ARB);
    end
`else
    // Without scrub the block arbitrates whenever reset is not held.
    always_comb begin
        arb_active  = ~reset_i;
        init_done_o = ~reset_i;
    end
`endif

    // Readies and transfers: the contended requester named by prio wins.
    always_comb begin
        alu_ready_o = arb_active & alu_valid_i & (~mem_valid_i | (prio_q == PRIO_ALU));
        mem_ready_o = arb_active & mem_valid_i & (~alu_valid_i | (prio_q == PRIO_MEM));
        alu_xfer    = alu_valid_i & alu_ready_o;
        mem_xfer    = mem_valid_i & mem_ready_o;
    end

    // Priority moves to whichever requester was not granted; holds when idle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)       prio_q <= PRIO_ALU;
        else if (alu_xfer) prio_q <= PRIO_MEM;
        else if (mem_xfer) prio_q <= PRIO_ALU;
    end

    // Registered write port: scrub zero-fill, else granted write; x0 writes are dropped at the enable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rf_regwrite_o <= 1'b0;
            rf_rd_o       <= '0;
            rf_wd_o       <= '0;
        end
`ifdef RF_WB_SCRUB_EN
        else if (scrub_wr) begin
            rf_regwrite_o <= 1'b1;
            rf_rd_o       <= cnt_q;
            rf_wd_o       <= '0;
        end
`endif
        else if (alu_xfer) begin
            rf_regwrite_o <= |alu_rd_i;
            rf_rd_o       <= alu_rd_i;
            rf_wd_o       <= alu_wd_i;
        end else if (mem_xfer) begin
            rf_regwrite_o <= |mem_rd_i;
            rf_rd_o       <= mem_rd_i;
            rf_wd_o       <= mem_wd_i;
        end else begin
            rf_regwrite_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Purpose: directed self-checking bench for rf_wb_arbiter (scrub tests when RF_WB_SCRUB_EN is defined).
// Latency: checks registered outputs one edge after each handshake.
// Backpressure: checks readies combinationally in the cycle the requests are presented.
module tb_rf_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            alu_valid_i = 1'b0;
    logic [AW-1:0]   alu_rd_i = '0;
    logic [XLEN-1:0] alu_wd_i = '0;
    logic            alu_ready_o;
    logic            mem_valid_i = 1'b0;
    logic [AW-1:0]   mem_rd_i = '0;
    logic [XLEN-1:0] mem_wd_i = '0;
    logic            mem_ready_o;
    logic            rf_regwrite_o;
    logic [AW-1:0]   rf_rd_o;
    logic [XLEN-1:0] rf_wd_o;
    logic            init_done_o;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_wd_i(alu_wd_i), .alu_ready_o(alu_ready_o),
        .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_wd_i(mem_wd_i), .mem_ready_o(mem_ready_o),
        .rf_regwrite_o(rf_regwrite_o), .rf_rd_o(rf_rd_o), .rf_wd_o(rf_wd_o), .init_done_o(init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic raw_reset();
        alu_valid_i = 1'b0;
        mem_valid_i = 1'b0;
        reset_i = 1'b1;
        #2;
        reset_i = 1'b0;
    endtask

    task automatic do_reset();
        raw_reset();
`ifdef RF_WB_SCRUB_EN
        repeat (NREGS) tick();
`endif
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rf_regwrite_o !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%0h exp=0", rf_regwrite_o); end
        checks++; if (rf_rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", rf_rd_o); end
        checks++; if (rf_wd_o !== 32'h0) begin errors++; $display("FAIL reset_wd got=%0h exp=0", rf_wd_o); end
        checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%0h exp=0", init_done_o); end
        alu_valid_i = 1'b1;
        #1;
        checks++; if (alu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got=%0h exp=0", alu_ready_o); end
        alu_valid_i = 1'b0;
        reset_i = 1'b0;
    endtask

`ifdef RF_WB_SCRUB_EN
    task automatic test_scrub();
        for (int i = 0; i < NREGS; i++) begin
            checks++; if ((alu_ready_o | mem_ready_o) !== 1'b0) begin errors++; $display("FAIL scrub_ready[%0d] got=%0h exp=0", i, alu_ready_o | mem_ready_o); end
            tick();
            checks++; if (rf_regwrite_o !== 1'b1 || rf_rd_o !== AW'(i) || rf_wd_o !== 32'h0)
                begin errors++; $display("FAIL scrub_write[%0d] got we=%0h rd=%0d wd=%0h exp we=1 rd=%0d wd=0", i, rf_regwrite_o, rf_rd_o, rf_wd_o, i); end
            checks++; if (init_done_o !== (i == NREGS - 1)) begin errors++; $display("FAIL scrub_init_done[%0d] got=%0h exp=%0h", i, init_done_o, i == NREGS - 1); end
        end
    endtask

    task automatic test_reset_mid_scrub();
        raw_reset();
        repeat (10) tick();
        alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_wd_i = 32'h44;
        #1;
        checks++; if (alu_ready_o !== 1'b0) begin errors++; $display("FAIL midscrub_ready got=%0h exp=0", alu_ready_o); end
        reset_i = 1'b1;
        #1;
        checks++; if (rf_regwrite_o !== 1'b0 || rf_rd_o !== 5'd0) begin errors++; $display("FAIL midscrub_clear got we=%0h rd=%0d exp we=0 rd=0", rf_regwrite_o, rf_rd_o); end
        reset_i = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            checks++; if (alu_ready_o !== 1'b0) begin errors++; $display("FAIL midscrub_hold[%0d] got=%0h exp=0", i, alu_ready_o); end
            tick();
            checks++; if (rf_rd_o !== AW'(i)) begin errors++; $display("FAIL midscrub_rd[%0d] got=%0d exp=%0d", i, rf_rd_o, i); end
        end
        checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL midscrub_ack got=%0h exp=1", alu_ready_o); end
        tick();
        alu_valid_i = 1'b0;
        checks++; if (rf_regwrite_o !== 1'b1 || rf_rd_o !== 5'd4 || rf_wd_o !== 32'h44)
            begin errors++; $display("FAIL midscrub_write got we=%0h rd=%0d wd=%0h exp we=1 rd=4 wd=44", rf_regwrite_o, rf_rd_o, rf_wd_o); end
    endtask
`else
    task automatic test_no_scrub();
        #1;
        checks++; if (init_done_o !== 1'b1) begin errors++; $display("FAIL noscrub_init_done got=%0h exp=1", init_done_o); end
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_wd_i = 32'hA5A5_0003;
        #1;
        checks++; if (alu_ready_o !== 1'b1 || mem_ready_o !== 1'b0) begin errors++; $display("FAIL noscrub_ready got alu=%0h mem=%0h exp alu=1 mem=0", alu_ready_o, mem_ready_o); end
        checks++; if (rf_regwrite_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_wd_o !== 32'h0)
            begin errors++; $display("FAIL noscrub_idle got we=%0h rd=%0d wd=%0h exp all 0", rf_regwrite_o, rf_rd_o, rf_wd_o); end
        tick();
        alu_valid_i = 1'b0;
        checks++; if (rf_regwrite_o !== 1'b1 || rf_rd_o !== 5'd3 || rf_wd_o !== 32'hA5A5_0003)
            begin errors++; $display("FAIL noscrub_write got we=%0h rd=%0d wd=%0h exp we=1 rd=3 wd=a5a50003", rf_regwrite_o, rf_rd_o, rf_wd_o); end
        tick();
        checks++; if (rf_regwrite_o !== 1'b0) begin errors++; $display("FAIL noscrub_idle_we got=%0h exp=0", rf_regwrite_o); end
    endtask
`endif

    task automatic test_single();
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_wd_i = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready got=%0h exp=1", alu_ready_o); end
        tick();
        alu_valid_i = 1'b0;
        checks++; if (rf_regwrite_o !== 1'b1 || rf_rd_o !== 5'd5 || rf_wd_o !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_write got we=%0h rd=%0d wd=%0h exp we=1 rd=5 wd=deadbeef", rf_regwrite_o, rf_rd_o, rf_wd_o); end
        tick();
        checks++; if (rf_regwrite_o !== 1'b0 || rf_rd_o !== 5'd5) begin errors++; $display("FAIL single_hold got we=%0h rd=%0d exp we=0 rd=5", rf_regwrite_o, rf_rd_o); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0]   exp_rd [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
        logic [XLEN-1:0] exp_wd [4] = '{32'h11, 32'h22, 32'h11, 32'h22};
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_wd_i = 32'h11;
        mem_valid_i = 1'b1; mem_rd_i = 5'd2; mem_wd_i = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (alu_ready_o !== (k % 2 == 0) || mem_ready_o !== (k % 2 == 1))
                begin errors++; $display("FAIL rr_ready[%0d] got alu=%0h mem=%0h exp alu=%0h mem=%0h", k, alu_ready_o, mem_ready_o, k % 2 == 0, k % 2 == 1); end
            tick();
            checks++; if (rf_regwrite_o !== 1'b1 || rf_rd_o !== exp_rd[k] || rf_wd_o !== exp_wd[k])
                begin errors++; $display("FAIL rr_write[%0d] got we=%0h rd=%0d wd=%0h exp we=1 rd=%0d wd=%0h", k, rf_regwrite_o, rf_rd_o, rf_wd_o, exp_rd[k], exp_wd[k]); end
        end
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
    endtask

    task automatic test_collision();
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_wd_i = 32'hAAAA;
        mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_wd_i = 32'hBBBB;
        tick();
        alu_valid_i = 1'b0;
        checks++; if (rf_rd_o !== 5'd7 || rf_wd_o !== 32'hAAAA) begin errors++; $display("FAIL coll_first got rd=%0d wd=%0h exp rd=7 wd=aaaa", rf_rd_o, rf_wd_o); end
        #1;
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL coll_loser_ready got=%0h exp=1", mem_ready_o); end
        tick();
        mem_valid_i = 1'b0;
        checks++; if (rf_regwrite_o !== 1'b1 || rf_rd_o !== 5'd7 || rf_wd_o !== 32'hBBBB)
            begin errors++; $display("FAIL coll_second got we=%0h rd=%0d wd=%0h exp we=1 rd=7 wd=bbbb", rf_regwrite_o, rf_rd_o, rf_wd_o); end
    endtask

    task automatic test_x0();
        mem_valid_i = 1'b1; mem_rd_i = 5'd0; mem_wd_i = 32'h1234;
        #1;
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready got=%0h exp=1", mem_ready_o); end
        tick();
        mem_valid_i = 1'b0;
        checks++; if (rf_regwrite_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_wd_o !== 32'h1234)
            begin errors++; $display("FAIL x0_write got we=%0h rd=%0d wd=%0h exp we=0 rd=0 wd=1234", rf_regwrite_o, rf_rd_o, rf_wd_o); end
    endtask

    task automatic test_reset_mid_op();
        alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_wd_i = 32'h99;
        tick();
        alu_rd_i = 5'd10; alu_wd_i = 32'h100;
        checks++; if (rf_regwrite_o !== 1'b1 || rf_rd_o !== 5'd9) begin errors++; $display("FAIL midop_write got we=%0h rd=%0d exp we=1 rd=9", rf_regwrite_o, rf_rd_o); end
        reset_i = 1'b1;
        #1;
        checks++; if (rf_regwrite_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_wd_o !== 32'h0)
            begin errors++; $display("FAIL midop_clear got we=%0h rd=%0d wd=%0h exp all 0", rf_regwrite_o, rf_rd_o, rf_wd_o); end
        checks++; if (alu_ready_o !== 1'b0 || init_done_o !== 1'b0) begin errors++; $display("FAIL midop_ready got rdy=%0h done=%0h exp 0 0", alu_ready_o, init_done_o); end
        alu_valid_i = 1'b0;
        reset_i = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef RF_WB_SCRUB_EN
        test_scrub();
`else
        test_no_scrub();
`endif
        test_single();
        do_reset();
        test_round_robin();
        test_collision();
        test_x0();
        test_reset_mid_op();
`ifdef RF_WB_SCRUB_EN
        test_reset_mid_scrub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
